// File: rtl/pcpi_issuer.sv
// pcpi_issuer: core-side PCPI initiator.
// Buffers (insn, rs1, rs2) commands in a small FIFO and issues them one at a
// time as PCPI transactions. Each transaction's result goes out on a
// valid/ready response stream. A transaction that sees neither pcpi_ready nor
// pcpi_wait for TIMEOUT_CYCLES consecutive cycles ends as an illegal-insn
// response (status 01).
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   cmd_valid/cmd_ready        command stream handshake
//   cmd_insn/cmd_rs1/cmd_rs2   command payload
//   rsp_valid/rsp_ready        response stream handshake
//   rsp_data/rsp_wr/rsp_status response payload (status 00 ok, 01 timeout)
//   pcpi_valid/insn/rs1/rs2    request side of the PCPI bus
//   pcpi_wr/rd/wait/ready      responder side of the PCPI bus
//   busy                       FIFO non-empty or transaction/response pending
//
// CMD_DEPTH must be a power of two and at least 2, so pointers wrap naturally.
module pcpi_issuer #(
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter int unsigned CMD_DEPTH      = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [31:0] cmd_insn,
   input  logic [31:0] cmd_rs1,
   input  logic [31:0] cmd_rs2,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        rsp_wr,
   output logic [1:0]  rsp_status,
   output logic        pcpi_valid,
   output logic [31:0] pcpi_insn,
   output logic [31:0] pcpi_rs1,
   output logic [31:0] pcpi_rs2,
   input  logic        pcpi_wr,
   input  logic [31:0] pcpi_rd,
   input  logic        pcpi_wait,
   input  logic        pcpi_ready,
   output logic        busy
);

   localparam int unsigned XLEN  = 32;
   localparam int unsigned PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(CMD_DEPTH + 1);
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_RESP  = 2'd2;

   localparam logic [1:0] STATUS_OK  = 2'b00;
   localparam logic [1:0] STATUS_TMO = 2'b01;

   typedef struct packed {
      logic [XLEN-1:0] insn;
      logic [XLEN-1:0] rs1;
      logic [XLEN-1:0] rs2;
   } cmd_t;

   // Command FIFO storage and bookkeeping
   cmd_t              fifo_q [CMD_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q,  count_d;
   logic              cmd_ready_q, cmd_ready_d;

   // Transaction control
   logic [1:0]        state_q, state_d;
   logic [TMO_W-1:0]  tmo_q,   tmo_d;
   logic              pcpi_valid_q, pcpi_valid_d;
   cmd_t              pcpi_cmd_q,   pcpi_cmd_d;

   // Response holding register
   logic              rsp_valid_q,  rsp_valid_d;
   logic [XLEN-1:0]   rsp_data_q,   rsp_data_d;
   logic              rsp_wr_q,     rsp_wr_d;
   logic [1:0]        rsp_status_q, rsp_status_d;

   logic              busy_q, busy_d;

   logic              push_c;
   logic              pop_c;
   cmd_t              cmd_in_c;

   assign cmd_in_c = '{insn: cmd_insn, rs1: cmd_rs1, rs2: cmd_rs2};

   // Next-state logic: FSM, FIFO bookkeeping, response capture
   always_comb begin
      state_d      = state_q;
      tmo_d        = tmo_q;
      pcpi_valid_d = pcpi_valid_q;
      pcpi_cmd_d   = pcpi_cmd_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_data_d   = rsp_data_q;
      rsp_wr_d     = rsp_wr_q;
      rsp_status_d = rsp_status_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      cmd_ready_d  = cmd_ready_q;
      busy_d       = busy_q;
      pop_c        = 1'b0;

      // cmd_ready is the registered !full, so a same-cycle pop never helps a push
      push_c = cmd_valid & cmd_ready_q;

      case (state_q)
         ST_IDLE: begin
            if (count_q != '0) begin
               pop_c        = 1'b1;
               pcpi_cmd_d   = fifo_q[rd_ptr_q];
               pcpi_valid_d = 1'b1;
               tmo_d        = '0;
               state_d      = ST_ISSUE;
            end
         end

         ST_ISSUE: begin
            // pcpi_ready has priority over a simultaneous pcpi_wait
            if (pcpi_ready) begin
               pcpi_valid_d = 1'b0;
               rsp_valid_d  = 1'b1;
               rsp_wr_d     = pcpi_wr;
               rsp_data_d   = pcpi_wr ? pcpi_rd : '0;
               rsp_status_d = STATUS_OK;
               tmo_d        = '0;
               state_d      = ST_RESP;
            end else if (pcpi_wait) begin
               tmo_d = '0;
            end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
               // this non-wait cycle would be the TIMEOUT_CYCLES-th in a row
               pcpi_valid_d = 1'b0;
               rsp_valid_d  = 1'b1;
               rsp_wr_d     = 1'b0;
               rsp_data_d   = '0;
               rsp_status_d = STATUS_TMO;
               tmo_d        = '0;
               state_d      = ST_RESP;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end

         ST_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end

         default: begin
            state_d      = ST_IDLE;
            pcpi_valid_d = 1'b0;
            rsp_valid_d  = 1'b0;
         end
      endcase

      if (push_c) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      case ({push_c, pop_c})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      cmd_ready_d = (count_d != CNT_W'(CMD_DEPTH));
      busy_d      = (count_d != '0) | (state_d != ST_IDLE);
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         tmo_q        <= '0;
         pcpi_valid_q <= 1'b0;
         pcpi_cmd_q   <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_data_q   <= '0;
         rsp_wr_q     <= 1'b0;
         rsp_status_q <= STATUS_OK;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         cmd_ready_q  <= 1'b1;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         tmo_q        <= tmo_d;
         pcpi_valid_q <= pcpi_valid_d;
         pcpi_cmd_q   <= pcpi_cmd_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_data_q   <= rsp_data_d;
         rsp_wr_q     <= rsp_wr_d;
         rsp_status_q <= rsp_status_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         cmd_ready_q  <= cmd_ready_d;
         busy_q       <= busy_d;
      end
   end

   // FIFO storage; contents need no reset because the pointers define validity
   always_ff @(posedge clk) begin
      if (!reset && push_c) begin
         fifo_q[wr_ptr_q] <= cmd_in_c;
      end
   end

   assign cmd_ready  = cmd_ready_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_data   = rsp_data_q;
   assign rsp_wr     = rsp_wr_q;
   assign rsp_status = rsp_status_q;
   assign pcpi_valid = pcpi_valid_q;
   assign pcpi_insn  = pcpi_cmd_q.insn;
   assign pcpi_rs1   = pcpi_cmd_q.rs1;
   assign pcpi_rs2   = pcpi_cmd_q.rs2;
   assign busy       = busy_q;

endmodule
